// File: rtl/praw_atom_pkg.sv
// Shared types for the praw_atom_array stateful atom: op and compare encodings.
// Saturation is enabled by defining PRAW_ATOM_SATURATE_EN (see praw_atom_alu).
package praw_atom_pkg;

  localparam int OP_WIDTH  = 2;
  localparam int CMP_WIDTH = 2;

  typedef enum logic [OP_WIDTH-1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_SET  = 2'd2,
    OP_PADD = 2'd3
  } op_e;

  typedef enum logic [CMP_WIDTH-1:0] {
    CMP_EQ = 2'd0,
    CMP_NE = 2'd1,
    CMP_LT = 2'd2,
    CMP_GE = 2'd3
  } cmp_e;

endpackage

// File: rtl/praw_atom_alu.sv
// Combinational compute for one atom access: operand muxing, op select, PADD predicate.
// Define PRAW_ATOM_SATURATE_EN to clamp ADD/PADD on carry-out and SUB on borrow.
module praw_atom_alu
  import praw_atom_pkg::*;
#(
  parameter int COUNT_WIDTH = 32
) (
  input  logic [COUNT_WIDTH-1:0] i_old,
  input  logic [COUNT_WIDTH-1:0] i_constant,
  input  logic [COUNT_WIDTH-1:0] i_pkt_1,
  input  logic [COUNT_WIDTH-1:0] i_pkt_2,
  input  logic                   i_sel1,
  input  logic                   i_sel2,
  input  op_e                    i_op,
  input  cmp_e                   i_cmp,
  output logic [COUNT_WIDTH-1:0] o_new,
  output logic                   o_updated
);

  logic [COUNT_WIDTH-1:0] w_a;
  logic [COUNT_WIDTH-1:0] w_b;
  logic [COUNT_WIDTH-1:0] w_sum;
  logic [COUNT_WIDTH-1:0] w_diff;
  logic                   w_pred;

  assign w_a = i_sel1 ? i_pkt_1 : i_constant;
  assign w_b = i_sel2 ? '0 : i_old;

`ifdef PRAW_ATOM_SATURATE_EN
  logic                   w_carry;
  logic [COUNT_WIDTH-1:0] w_sumRaw;

  assign {w_carry, w_sumRaw} = {1'b0, w_b} + {1'b0, w_a};
  assign w_sum  = w_carry ? '1 : w_sumRaw;
  assign w_diff = (w_b < w_a) ? '0 : (w_b - w_a);
`else
  assign w_sum  = w_b + w_a;
  assign w_diff = w_b - w_a;
`endif

  // The predicate always looks at the true old value, even when sel2 zeroes operand B.
  always_comb begin
    w_pred = 1'b0;
    case (i_cmp)
      CMP_EQ:  w_pred = (i_old == i_pkt_2);
      CMP_NE:  w_pred = (i_old != i_pkt_2);
      CMP_LT:  w_pred = (i_old <  i_pkt_2);
      CMP_GE:  w_pred = (i_old >= i_pkt_2);
      default: w_pred = 1'b0;
    endcase
  end

  always_comb begin
    o_new     = i_old;
    o_updated = 1'b1;
    case (i_op)
      OP_ADD:  o_new = w_sum;
      OP_SUB:  o_new = w_diff;
      OP_SET:  o_new = w_a;
      OP_PADD: begin
        o_updated = w_pred;
        o_new     = w_pred ? w_sum : i_old;
      end
      default: o_new = i_old;
    endcase
  end

endmodule

// File: rtl/praw_atom_array.sv
// Two-stage stateful atom over NUM_REGS registers with same-index forwarding.
// Optional saturation via PRAW_ATOM_SATURATE_EN, implemented inside praw_atom_alu.
module praw_atom_array
  import praw_atom_pkg::*;
#(
  parameter  int COUNT_WIDTH = 32,
  parameter  int NUM_REGS    = 16,
  localparam int IDX_WIDTH   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i__valid,
  input  logic [IDX_WIDTH-1:0]   i__idx,
  input  logic [COUNT_WIDTH-1:0] i__constant,
  input  logic [COUNT_WIDTH-1:0] i__pkt_1,
  input  logic [COUNT_WIDTH-1:0] i__pkt_2,
  input  logic                   i__sel1,
  input  logic                   i__sel2,
  input  logic [OP_WIDTH-1:0]    i__op,
  input  logic [CMP_WIDTH-1:0]   i__cmp,
  output logic                   o__valid,
  output logic [IDX_WIDTH-1:0]   o__idx,
  output logic [COUNT_WIDTH-1:0] o__read,
  output logic [COUNT_WIDTH-1:0] o__write,
  output logic                   o__updated
);

  logic [COUNT_WIDTH-1:0] r_state [NUM_REGS];

  logic                   r1Valid;
  logic [IDX_WIDTH-1:0]   r1Idx;
  logic [COUNT_WIDTH-1:0] r1Constant;
  logic [COUNT_WIDTH-1:0] r1Pkt1;
  logic [COUNT_WIDTH-1:0] r1Pkt2;
  logic                   r1Sel1;
  logic                   r1Sel2;
  op_e                    r1Op;
  cmp_e                   r1Cmp;

  logic                   r2Valid;
  logic [IDX_WIDTH-1:0]   r2Idx;
  logic [COUNT_WIDTH-1:0] r2Old;
  logic [COUNT_WIDTH-1:0] r2New;
  logic                   r2Updated;

  logic                   w_inRange;
  logic                   w_forward;
  logic [COUNT_WIDTH-1:0] w_old;
  logic [COUNT_WIDTH-1:0] w_new;
  logic                   w_aluUpdated;

  // S2 commits at the next edge, so its value is the freshest copy of a matching index.
  // r2Updated is only ever set for in-range indices, so out-of-range packets never forward.
  assign w_inRange = int'(r1Idx) < NUM_REGS;
  assign w_forward = r2Valid && r2Updated && (r2Idx == r1Idx);
  assign w_old     = !w_inRange ? '0 : (w_forward ? r2New : r_state[r1Idx]);

  praw_atom_alu #(
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_alu (
    .i_old      (w_old),
    .i_constant (r1Constant),
    .i_pkt_1    (r1Pkt1),
    .i_pkt_2    (r1Pkt2),
    .i_sel1     (r1Sel1),
    .i_sel2     (r1Sel2),
    .i_op       (r1Op),
    .i_cmp      (r1Cmp),
    .o_new      (w_new),
    .o_updated  (w_aluUpdated)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r1Valid <= 1'b0;
      r2Valid <= 1'b0;
    end else begin
      r1Valid    <= i__valid;
      r1Idx      <= i__idx;
      r1Constant <= i__constant;
      r1Pkt1     <= i__pkt_1;
      r1Pkt2     <= i__pkt_2;
      r1Sel1     <= i__sel1;
      r1Sel2     <= i__sel2;
      r1Op       <= op_e'(i__op);
      r1Cmp      <= cmp_e'(i__cmp);
      r2Valid    <= r1Valid;
      r2Idx      <= r1Idx;
      r2Old      <= w_old;
      r2New      <= w_new;
      r2Updated  <= w_aluUpdated && w_inRange;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_state[i] <= '0;
      end
    end else if (r2Valid && r2Updated) begin
      r_state[r2Idx] <= r2New;
    end
  end

  // Result fields hold across bubbles; only o__valid drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      o__valid   <= 1'b0;
      o__idx     <= '0;
      o__read    <= '0;
      o__write   <= '0;
      o__updated <= 1'b0;
    end else begin
      o__valid <= r2Valid;
      if (r2Valid) begin
        o__idx     <= r2Idx;
        o__read    <= r2Old;
        o__write   <= r2New;
        o__updated <= r2Updated;
      end
    end
  end

endmodule

// File: tb/tb_praw_atom_array.sv
// Self-checking bench for praw_atom_array: directed scenarios plus random traffic
// against a sequential reference model; honours PRAW_ATOM_SATURATE_EN.
module tb_praw_atom_array;

  localparam int CW = 32;
  localparam int NR = 12;
  localparam int IW = 4;

  typedef struct {
    logic          rst;
    logic          valid;
    logic [IW-1:0] idx;
    logic [CW-1:0] cnst;
    logic [CW-1:0] p1;
    logic [CW-1:0] p2;
    logic          sel1;
    logic          sel2;
    logic [1:0]    op;
    logic [1:0]    cmp;
  } pkt_t;

  typedef struct {
    logic          valid;
    logic [IW-1:0] idx;
    logic [CW-1:0] rd;
    logic [CW-1:0] wr;
    logic          upd;
  } res_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          iValid;
  logic [IW-1:0] iIdx;
  logic [CW-1:0] iConstant;
  logic [CW-1:0] iPkt1;
  logic [CW-1:0] iPkt2;
  logic          iSel1;
  logic          iSel2;
  logic [1:0]    iOp;
  logic [1:0]    iCmp;
  logic          oValid;
  logic [IW-1:0] oIdx;
  logic [CW-1:0] oRead;
  logic [CW-1:0] oWrite;
  logic          oUpdated;

  logic [CW-1:0] model [NR];
  res_t          s1;
  res_t          s2;
  res_t          expOut;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  praw_atom_array #(
    .COUNT_WIDTH (CW),
    .NUM_REGS    (NR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i__valid    (iValid),
    .i__idx      (iIdx),
    .i__constant (iConstant),
    .i__pkt_1    (iPkt1),
    .i__pkt_2    (iPkt2),
    .i__sel1     (iSel1),
    .i__sel2     (iSel2),
    .i__op       (iOp),
    .i__cmp      (iCmp),
    .o__valid    (oValid),
    .o__idx      (oIdx),
    .o__read     (oRead),
    .o__write    (oWrite),
    .o__updated  (oUpdated)
  );

  // Counts one comparison and reports it when actual and expected differ.
  task automatic checkOutput(input string tag, input logic [CW-1:0] actual, input logic [CW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Reference: packets take effect one after another on a plain array, in arrival order.
  function automatic res_t modelPacket(input pkt_t p);
    res_t          r;
    logic          inRange;
    logic [CW-1:0] oldV;
    logic [CW-1:0] a;
    logic [CW-1:0] b;
    logic [CW:0]   wide;
    logic [CW-1:0] addRes;
    logic [CW-1:0] subRes;
    logic          pred;
    logic [CW-1:0] nw;
    logic          upd;
    inRange = int'(p.idx) < NR;
    oldV    = inRange ? model[p.idx] : '0;
    a       = p.sel1 ? p.p1 : p.cnst;
    b       = p.sel2 ? '0 : oldV;
    wide    = {1'b0, b} + {1'b0, a};
    addRes  = wide[CW-1:0];
    subRes  = b - a;
`ifdef PRAW_ATOM_SATURATE_EN
    if (wide[CW]) addRes = '1;
    if (b < a) subRes = '0;
`endif
    case (p.cmp)
      2'd0:    pred = (oldV == p.p2);
      2'd1:    pred = (oldV != p.p2);
      2'd2:    pred = (oldV < p.p2);
      default: pred = (oldV >= p.p2);
    endcase
    upd = 1'b1;
    case (p.op)
      2'd0:    nw = addRes;
      2'd1:    nw = subRes;
      2'd2:    nw = a;
      default: begin
        upd = pred;
        nw  = pred ? addRes : oldV;
      end
    endcase
    if (!inRange) upd = 1'b0;
    if (upd) model[p.idx] = nw;
    r.valid = 1'b1;
    r.idx   = p.idx;
    r.rd    = oldV;
    r.wr    = nw;
    r.upd   = upd;
    return r;
  endfunction

  function automatic pkt_t mk(input logic v, input int idx, input logic [CW-1:0] cnst,
                              input logic [CW-1:0] p1, input logic [CW-1:0] p2,
                              input logic sel1, input logic sel2, input int op, input int cmp);
    pkt_t p;
    p.rst   = 1'b0;
    p.valid = v;
    p.idx   = IW'(idx);
    p.cnst  = cnst;
    p.p1    = p1;
    p.p2    = p2;
    p.sel1  = sel1;
    p.sel2  = sel2;
    p.op    = 2'(op);
    p.cmp   = 2'(cmp);
    return p;
  endfunction

  function automatic pkt_t idle();
    return mk(1'b0, 0, '0, '0, '0, 1'b0, 1'b0, 0, 0);
  endfunction

  function automatic void clearModel();
    for (int i = 0; i < NR; i++) model[i] = '0;
    s1     = '{default: '0};
    s2     = '{default: '0};
    expOut = '{default: '0};
  endfunction

  // One clock: check outputs from previous edges, drive a packet, advance the expected pipeline.
  task automatic applyStimulus(input pkt_t p);
    res_t cur;
    @(negedge clk);
    checkOutput("o_valid",   CW'(oValid),   CW'(expOut.valid));
    checkOutput("o_idx",     CW'(oIdx),     CW'(expOut.idx));
    checkOutput("o_read",    oRead,         expOut.rd);
    checkOutput("o_write",   oWrite,        expOut.wr);
    checkOutput("o_updated", CW'(oUpdated), CW'(expOut.upd));
    rst       = p.rst;
    iValid    = p.valid;
    iIdx      = p.idx;
    iConstant = p.cnst;
    iPkt1     = p.p1;
    iPkt2     = p.p2;
    iSel1     = p.sel1;
    iSel2     = p.sel2;
    iOp       = p.op;
    iCmp      = p.cmp;
    cur = '{default: '0};
    if (p.valid && !p.rst) cur = modelPacket(p);
    @(posedge clk);
    if (p.rst) begin
      clearModel();
    end else begin
      if (s2.valid) expOut = s2;
      else expOut.valid = 1'b0;
      s2 = s1;
      s1 = cur;
    end
    #1;
  endtask

  function automatic logic [CW-1:0] randVal();
    case ($urandom_range(0, 3))
      0:       return CW'($urandom_range(0, 20));
      1:       return 32'hFFFF_FFFF - CW'($urandom_range(0, 5));
      default: return CW'($urandom);
    endcase
  endfunction

  initial begin
    pkt_t p;
    rst = 1'b1; iValid = 1'b0; iIdx = '0; iConstant = '0; iPkt1 = '0; iPkt2 = '0;
    iSel1 = 1'b0; iSel2 = 1'b0; iOp = '0; iCmp = '0;
    clearModel();
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] ADD sequence on idx 3");
    repeat (4) applyStimulus(mk(1, 3, 5, 0, 0, 0, 0, 0, 0));
    applyStimulus(idle());
    applyStimulus(idle());
    checkOutput("add_seq_read", oRead, 32'd15);
    checkOutput("add_seq_write", oWrite, 32'd20);

    $display("[TB] forwarding back-to-back and across a bubble");
    applyStimulus(mk(1, 2, 0, 100, 0, 1, 0, 2, 0));
    applyStimulus(mk(1, 2, 1, 0, 0, 0, 0, 0, 0));
    applyStimulus(idle());
    applyStimulus(idle());
    checkOutput("fwd_read", oRead, 32'd100);
    checkOutput("fwd_write", oWrite, 32'd101);
    applyStimulus(mk(1, 2, 0, 100, 0, 1, 0, 2, 0));
    applyStimulus(idle());
    applyStimulus(mk(1, 2, 1, 0, 0, 0, 0, 0, 0));
    applyStimulus(idle());
    applyStimulus(idle());
    checkOutput("fwd_bubble_write", oWrite, 32'd101);

    $display("[TB] wrap / saturation on idx 0");
    applyStimulus(mk(1, 0, 0, 32'hFFFF_FFFF, 0, 1, 0, 2, 0));
    applyStimulus(mk(1, 0, 2, 0, 0, 0, 0, 0, 0));
    applyStimulus(idle());
    applyStimulus(idle());
`ifdef PRAW_ATOM_SATURATE_EN
    checkOutput("wrap_add", oWrite, 32'hFFFF_FFFF);
`else
    checkOutput("wrap_add", oWrite, 32'd1);
`endif
    applyStimulus(mk(1, 0, 0, 1, 0, 1, 0, 2, 0));
    applyStimulus(mk(1, 0, 3, 0, 0, 0, 0, 1, 0));
    applyStimulus(idle());
    applyStimulus(idle());
`ifdef PRAW_ATOM_SATURATE_EN
    checkOutput("wrap_sub", oWrite, 32'd0);
`else
    checkOutput("wrap_sub", oWrite, 32'hFFFF_FFFE);
`endif

    $display("[TB] predicated add on idx 7");
    applyStimulus(mk(1, 7, 0, 10, 0, 1, 0, 2, 0));
    applyStimulus(mk(1, 7, 1, 0, 20, 0, 0, 3, 2));
    applyStimulus(idle());
    applyStimulus(idle());
    checkOutput("padd_true_write", oWrite, 32'd11);
    checkOutput("padd_true_upd", CW'(oUpdated), 32'd1);
    applyStimulus(mk(1, 7, 1, 0, 5, 0, 0, 3, 2));
    applyStimulus(mk(1, 7, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(idle());
    applyStimulus(idle());
    checkOutput("padd_false_state", oRead, 32'd11);

    $display("[TB] reset with a packet in flight");
    applyStimulus(mk(1, 1, 0, 50, 0, 1, 0, 2, 0));
    applyStimulus(idle());
    applyStimulus(idle());
    applyStimulus(mk(1, 1, 9, 0, 0, 0, 0, 0, 0));
    p = mk(1, 1, 9, 0, 0, 0, 0, 0, 0);
    p.rst = 1'b1;
    applyStimulus(p);
    checkOutput("rst_valid", CW'(oValid), 32'd0);
    applyStimulus(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(idle());
    applyStimulus(idle());
    checkOutput("rst_read", oRead, 32'd0);

    $display("[TB] out-of-range indices");
    applyStimulus(mk(1, 13, 4, 0, 0, 0, 0, 0, 0));
    applyStimulus(mk(1, 12, 4, 0, 0, 0, 0, 0, 0));
    applyStimulus(idle());
    applyStimulus(idle());
    checkOutput("oor_upd", CW'(oUpdated), 32'd0);
    checkOutput("oor_read", oRead, 32'd0);
    checkOutput("oor_write", oWrite, 32'd4);
    for (int i = 0; i < NR; i++) applyStimulus(mk(1, i, 0, 0, 0, 0, 0, 0, 0));

    $display("[TB] random traffic");
    for (int n = 0; n < 600; n++) begin
      p.rst   = ($urandom_range(0, 59) == 0);
      p.valid = ($urandom_range(0, 9) < 8);
      p.idx   = ($urandom_range(0, 1) == 0) ? IW'($urandom_range(0, 3)) : IW'($urandom_range(0, 15));
      p.cnst  = randVal();
      p.p1    = randVal();
      p.p2    = randVal();
      p.sel1  = 1'($urandom_range(0, 1));
      p.sel2  = ($urandom_range(0, 3) == 0);
      p.op    = 2'($urandom_range(0, 3));
      p.cmp   = 2'($urandom_range(0, 3));
      applyStimulus(p);
    end
    repeat (3) applyStimulus(idle());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/praw_atom_array.md
Name: praw_atom_array

Overview:
- Pipelined stateful atom for the packet-transaction datapath. It holds NUM_REGS state registers instead of one, selected per packet by index.
- Adds an op select (add, sub, set, predicated add) and a compare predicate.
- Sits at a pipeline stage slot and accepts one packet per cycle with no backpressure.
- Back-to-back accesses to the same register index are forwarded, so each packet sees the value left by the packet before it.

Parameters:
- COUNT_WIDTH, 32: width of state registers, operands and results.
- NUM_REGS, 16: number of state registers (>=1; need not be a power of two).
- IDX_WIDTH, derived localparam = max(1, $clog2(NUM_REGS)): index width.

Ports:
- clk, input, 1: single clock; all state updates on posedge.
- rst, input, 1: synchronous, active-high reset.
- i__valid, input, 1: packet present this cycle.
- i__idx, input, IDX_WIDTH: state register index.
- i__constant, input, COUNT_WIDTH: configured immediate operand.
- i__pkt_1, input, COUNT_WIDTH: packet field operand.
- i__pkt_2, input, COUNT_WIDTH: packet field used as predicate compare value.
- i__sel1, input, 1: operand A = sel1 ? pkt_1 : constant.
- i__sel2, input, 1: operand B = sel2 ? 0 : state[idx].
- i__op, input, 2: 0 ADD, 1 SUB, 2 SET, 3 PADD.
- i__cmp, input, 2: predicate for PADD: 0 EQ, 1 NE, 2 LT (unsigned), 3 GE (unsigned); compares state[idx] against pkt_2.
- o__valid, output, 1: result valid.
- o__idx, output, IDX_WIDTH: index of the result.
- o__read, output, COUNT_WIDTH: state value before the update.
- o__write, output, COUNT_WIDTH: state value after the update.
- o__updated, output, 1: state register was written.

Behaviour:
- Two-stage pipeline, latency 2. A packet accepted at edge N appears on outputs after edge N+2. Throughput is 1 packet/cycle; there is no stall and no ready signal.
- Stage S1, registered at edge N: captures inputs and reads state[idx]. The read is forwarded from S2 when S2 holds a valid packet with the same idx that is writing this cycle.
- Stage S2, registered at edge N+1: computes the new value and commits it to the array at edge N+2. The output registers load at the same edge.
- Compute, with A and B as defined under Ports:
  - ADD: new = B + A.
  - SUB: new = B - A.
  - SET: new = A.
  - PADD: new = B + A if cmp(old, pkt_2) is true, else new = old.
- Updated flag: o__updated = 1 for ADD, SUB and SET. For PADD it equals the predicate result.
- Outputs: o__read = old, o__write = new. If updated=0, o__write = old.
- Arithmetic is modulo 2^COUNT_WIDTH: wrap on overflow and underflow, no flags.
- Out-of-range idx (idx >= NUM_REGS):
  - no array write; o__read = 0, o__write = computed value with old = 0, o__updated = 0;
  - never forwarded.
- Invalid cycles (i__valid=0): the bubble propagates, there are no writes, and o__valid=0. In that case o__idx, o__read, o__write and o__updated hold their previous values.
- Reset:
  - all state registers are 0; o__valid, o__updated, o__read, o__write and o__idx are 0;
  - pipeline valids are cleared, so in-flight packets are dropped without writing;
  - a packet presented in the same cycle as rst is dropped;
  - the first packet accepted in the cycle after rst deasserts sees state = 0.
- Simultaneous events: same idx in S1 and S2 uses forwarding. Different indices proceed independently; forwarding never corrupts another index.

Optional Feature:
- Macro: PRAW_ATOM_SATURATE_EN.
- Defined:
  - ADD and PADD clamp to 2^COUNT_WIDTH-1 on carry-out; SUB clamps to 0 on borrow.
  - o__updated is still 1 when the value is clamped.
- Undefined: pure modulo arithmetic as above.
- Forwarding carries the clamped value.

Decomposition:
- Package praw_atom_pkg:
  - op enum (OP_ADD, OP_SUB, OP_SET, OP_PADD);
  - cmp enum (CMP_EQ, CMP_NE, CMP_LT, CMP_GE);
  - 2-bit widths of both enums.
- Sub-module praw_atom_alu, purely combinational:
  - inputs old, constant, pkt_1, pkt_2, sel1, sel2, op, cmp;
  - outputs new value and updated.
  - Saturation logic lives in this sub-module.
- Top holds the array, the pipeline registers and the forwarding compare.

Test Plan:
- Reset then ADD: idx=3, constant=5, sel1=0, sel2=0, 4 consecutive cycles. o__read = 0,5,10,15 and o__write = 5,10,15,20; first o__valid exactly 2 cycles after first i__valid.
- Forwarding: cycle0 SET idx=2 pkt_1=100 sel1=1; cycle1 ADD idx=2 constant=1. Outputs (100 then read=100, write=101). Repeat with a bubble between: same result.
- Wrap: SET idx=0 to 0xFFFFFFFF, then ADD constant=2 gives o__write=1. SUB constant=3 from 1 gives 0xFFFFFFFE. With PRAW_ATOM_SATURATE_EN: the ADD gives 0xFFFFFFFF and the SUB from 1 gives 0.
- PADD: state[7]=10, cmp=LT, pkt_2=20, constant=1 gives write=11, updated=1. Then pkt_2=5 gives write=11, updated=0, and state[7] stays 11.
- Reset mid-flight: issue ADD idx=1 constant=9, assert rst one cycle later. o__valid stays 0; after release, a read via ADD constant=0 on idx=1 returns o__read=0.
- NUM_REGS=12, idx=13 ADD constant=4: o__updated=0, o__read=0. Back-to-back idx=13 then idx=12 causes no forwarding and no write to any register.
